// File: rtl/prog_loader.sv
// prog_loader: streams a length-prefixed program image into instruction memory.
// A 16-bit big-endian word count header is followed by word_count*4 bytes,
// each written to consecutive byte addresses starting at 0. The CPU is held in
// reset until the image is complete.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 load request (honoured in IDLE, DONE, ERR)
//   byte_valid/byte_data  upstream byte stream
//   byte_ready            loader accepts a byte this cycle
//   imem_we/addr/wdata    single-cycle byte write to instruction memory
//   cpu_reset             high except when a load has completed
//   busy/done/error       status flags
module prog_loader #(
    parameter int unsigned IMEM_BYTES = 320
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [7:0]  imem_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // 16-bit word count times 4 needs 18 bits.
    localparam int unsigned AW = 18;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     wc_q, wc_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wr_d;
    logic            xfer;
    logic [15:0]     hdr_wc;
    logic [AW-1:0]   hdr_bytes;
    logic [AW-1:0]   last_addr;

    // byte_ready is registered and only high in accepting states.
    assign xfer      = byte_valid & byte_ready;
    assign hdr_wc    = {wc_q[15:8], byte_data};
    assign hdr_bytes = {hdr_wc, 2'b00};
    assign last_addr = {wc_q, 2'b00} - AW'(1);

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        addr_d  = addr_q;
        wr_d    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_d = S_HDR_HI;
            end
            S_HDR_HI: begin
                if (xfer) begin
                    wc_d    = {byte_data, wc_q[7:0]};
                    state_d = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (xfer) begin
                    wc_d = hdr_wc;
                    if ((hdr_wc == 16'd0) || (32'(hdr_bytes) > 32'(IMEM_BYTES))) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                        addr_d  = '0;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    wr_d   = 1'b1;
                    addr_d = addr_q + AW'(1);
                    if (addr_q == last_addr) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; status reflects the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wc_q       <= '0;
            addr_q     <= '0;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wc_q       <= wc_d;
            addr_q     <= addr_d;
            imem_we    <= wr_d;
            if (wr_d) begin
                imem_addr  <= 32'(addr_q);
                imem_wdata <= byte_data;
            end
            byte_ready <= (state_d == S_HDR_HI) || (state_d == S_HDR_LO) || (state_d == S_DATA);
            busy       <= (state_d == S_HDR_HI) || (state_d == S_HDR_LO) || (state_d == S_DATA);
            done       <= (state_d == S_DONE);
            error      <= (state_d == S_ERR);
            cpu_reset  <= (state_d != S_DONE);
        end
    end

endmodule
